// File: rtl/pulse_encoder.sv
// Transmit side of the pulse-interval optical link: serialises one frame into single-cycle pulses.
// Ports: clock/reset (sync, active-high), data/start in, ready/signal/done out.
// Latency: start pulse one cycle after acceptance; done strobes in the first IDLE cycle after the trailer.
// Backpressure: ready is high only in IDLE; start while ready is low is ignored.
module pulse_encoder #(
    parameter int FRAME_SIZE    = 8,
    parameter int INTERVAL_LOW  = 4,
    parameter int INTERVAL_HIGH = 8,
    parameter int GAP_CYCLES    = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FRAME_SIZE-1:0] data,
    input  logic                  start,
    output logic                  ready,
    output logic                  signal,
    output logic                  done
);

    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam int BW = $clog2(FRAME_SIZE) + 1;

    // Terminal values of the low/trail counter (it counts 0..N-1).
    localparam logic [CW-1:0] LOW0_LAST = CW'(INTERVAL_LOW - 2);
    localparam logic [CW-1:0] LOW1_LAST = CW'(INTERVAL_HIGH - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_SIZE - 1);

    // Reject parameter sets that would produce adjacent pulses or a trailer
    // too short to time out a decoder stuck mid-frame.
    if (FRAME_SIZE < 1 || INTERVAL_LOW < 2 || INTERVAL_HIGH <= INTERVAL_LOW ||
        GAP_CYCLES < INTERVAL_HIGH + 2) begin : g_param_check
        $error("pulse_encoder: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOW,
        S_PULSE,
        S_TRAIL
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_SIZE-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [BW-1:0]         bit_q,   bit_d;
    logic                  done_q,  done_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_LOW;
            end
            S_LOW: begin
                // Gap length is chosen by the bit currently at the LSB.
                if (cnt_q == (shift_q[0] ? LOW1_LAST : LOW0_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PULSE: begin
                if (bit_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_TRAIL;
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    state_d = S_LOW;
                end
            end
            S_TRAIL: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready  = (state_q == S_IDLE);
    assign signal = (state_q == S_START) || (state_q == S_PULSE);
    // done_q is only set on the TRAIL->IDLE transition, so it coincides with ready.
    assign done   = done_q;

endmodule
